cv32e41p_event_log: RTL and testbench

//  Multi-channel decode-event logger. Captures per-channel event counts and a

---
 rtl/cv32e41p_event_log.sv | 185 ++++++++++++++++++
 tb/tb_cv32e41p_event_log.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e41p_event_log.sv
// ---------------------------------------------------------------------------
// cv32e41p_event_log
//
// Purpose:
//   Decode-event logger sitting beside the core. Keeps one saturating counter
//   per event channel and a small FIFO of timestamped records
//   {channel, PC, timestamp}. A consumer drains the FIFO over a valid/ready
//   port.
//
// Optional feature (macro CV32E41P_EVENT_LOG_DISPLAY_EN):
//   When defined, prints the parameter values at start-up, one line per
//   qualified event channel, and one line per dropped record. When undefined
//   the block contains no simulation-only code; ports and timing are the same.
//
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   is_decoding_i     qualifies event_i
//   event_i           per-channel event strobes (channel 0 = top priority)
//   pc_id_i           PC of the instruction in ID, stored with each record
//   hart_id_i         hart id, only used for display
//   clear_i           synchronous clear of counters, FIFO and overflow flag
//   rd_ready_i        consumer accepts the head record
//   rd_valid_o        FIFO non-empty
//   rd_event_o        channel index of the head record
//   rd_pc_o           PC of the head record
//   rd_ts_o           timestamp of the head record
//   level_o           FIFO occupancy, 0..DEPTH
//   overflow_o        sticky flag: a record was dropped because FIFO was full
//   count_o           counters, channel k at [k*CNT_WIDTH +: CNT_WIDTH]
//
// Read handshake: a record is removed when rd_valid_o & rd_ready_i at a rising
// clock edge; rd_ready_i is ignored while empty; head fields stay stable while
// rd_valid_o & !rd_ready_i.
// ---------------------------------------------------------------------------
module cv32e41p_event_log #(
  parameter int NUM_EVENTS = 4,
  parameter int DEPTH      = 8,
  parameter int CNT_WIDTH  = 16,
  parameter int TS_WIDTH   = 32,
  localparam int EW        = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1,
  localparam int PW        = $clog2(DEPTH),
  localparam int LW        = $clog2(DEPTH) + 1
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            is_decoding_i,
  input  logic [NUM_EVENTS-1:0]           event_i,
  input  logic [31:0]                     pc_id_i,
  input  logic [31:0]                     hart_id_i,
  input  logic                            clear_i,
  input  logic                            rd_ready_i,
  output logic                            rd_valid_o,
  output logic [EW-1:0]                   rd_event_o,
  output logic [31:0]                     rd_pc_o,
  output logic [TS_WIDTH-1:0]             rd_ts_o,
  output logic [LW-1:0]                   level_o,
  output logic                            overflow_o,
  output logic [NUM_EVENTS*CNT_WIDTH-1:0] count_o
);

  logic [TS_WIDTH-1:0]  r_ts;
  logic [EW-1:0]        r_ev_mem [DEPTH];
  logic [31:0]          r_pc_mem [DEPTH];
  logic [TS_WIDTH-1:0]  r_ts_mem [DEPTH];
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [LW-1:0]        r_level;
  logic                 r_overflow;
  logic [CNT_WIDTH-1:0] r_cnt [NUM_EVENTS];

  logic          w_hit;
  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_first;
  logic          w_unused_hart;

  // hart_id_i only feeds the optional display path.
  assign w_unused_hart = ^hart_id_i;

  assign w_hit  = is_decoding_i & (|event_i);
  assign w_full = (r_level == LW'(DEPTH));
  assign w_pop  = rd_valid_o & rd_ready_i;
  // A pop in the same cycle frees the slot, so a push on full is accepted.
  assign w_push = w_hit & (~w_full | w_pop);
  assign w_drop = w_hit & w_full & ~w_pop;

  // Lowest set channel wins the record; scanning downward leaves it last.
  always_comb begin
    w_first = '0;
    for (int k = NUM_EVENTS - 1; k >= 0; k--) begin
      if (event_i[k]) w_first = EW'(k);
    end
  end

  // Free-running timestamp, deliberately untouched by clear_i.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_ts <= '0;
    else         r_ts <= r_ts + 1'b1;
  end

  // Storage is reset so the head fields read 0 while empty after reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_ev_mem[i] <= '0;
        r_pc_mem[i] <= '0;
        r_ts_mem[i] <= '0;
      end
    end else if (w_push && !clear_i) begin
      r_ev_mem[r_wr_ptr] <= w_first;
      r_pc_mem[r_wr_ptr] <= pc_id_i;
      r_ts_mem[r_wr_ptr] <= r_ts;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (clear_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Every qualified channel counts, even those that lost the record slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_EVENTS; k++) r_cnt[k] <= '0;
    end else if (clear_i) begin
      for (int k = 0; k < NUM_EVENTS; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_EVENTS; k++) begin
        if (is_decoding_i && event_i[k] && (r_cnt[k] != {CNT_WIDTH{1'b1}}))
          r_cnt[k] <= r_cnt[k] + 1'b1;
      end
    end
  end

  always_comb begin
    count_o = '0;
    for (int k = 0; k < NUM_EVENTS; k++) count_o[k*CNT_WIDTH +: CNT_WIDTH] = r_cnt[k];
  end

  assign rd_valid_o = (r_level != '0);
  assign rd_event_o = r_ev_mem[r_rd_ptr];
  assign rd_pc_o    = r_pc_mem[r_rd_ptr];
  assign rd_ts_o    = r_ts_mem[r_rd_ptr];
  assign level_o    = r_level;
  assign overflow_o = r_overflow;

`ifdef CV32E41P_EVENT_LOG_DISPLAY_EN
  initial begin
    $display("cv32e41p_event_log: NUM_EVENTS=%0d DEPTH=%0d CNT_WIDTH=%0d TS_WIDTH=%0d",
             NUM_EVENTS, DEPTH, CNT_WIDTH, TS_WIDTH);
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      for (int k = 0; k < NUM_EVENTS; k++) begin
        if (is_decoding_i && event_i[k])
          $display("%t: Event %0d (core %0d) at PC 0x%h", $time, k, hart_id_i[3:0], pc_id_i);
      end
      if (w_drop && !clear_i)
        $display("%t: FIFO overflow (core %0d) at PC 0x%h", $time, hart_id_i[3:0], pc_id_i);
    end
  end
`endif

endmodule

// File: tb/tb_cv32e41p_event_log.sv
// ---------------------------------------------------------------------------
// tb_cv32e41p_event_log
//
// Directed bench for cv32e41p_event_log built with CNT_WIDTH=4 so counter
// saturation is reachable quickly. Inputs change on the falling edge and
// outputs are checked on the falling edge. A small reference model (record
// queue, saturating counters, overflow flag, cycle counter) is updated by the
// driver task for every cycle driven.
// ---------------------------------------------------------------------------
module tb_cv32e41p_event_log;

  localparam int NE  = 4;
  localparam int DEP = 8;
  localparam int CW  = 4;
  localparam int TW  = 32;
  localparam int EW  = 2;
  localparam int RW  = EW + 32 + TW;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              is_decoding;
  logic [NE-1:0]     event_v;
  logic [31:0]       pc_id;
  logic [31:0]       hart_id;
  logic              clear;
  logic              rd_ready;
  logic              rd_valid;
  logic [EW-1:0]     rd_event;
  logic [31:0]       rd_pc;
  logic [TW-1:0]     rd_ts;
  logic [3:0]        level;
  logic              overflow;
  logic [NE*CW-1:0]  count;

  cv32e41p_event_log #(
    .NUM_EVENTS(NE), .DEPTH(DEP), .CNT_WIDTH(CW), .TS_WIDTH(TW)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .is_decoding_i (is_decoding),
    .event_i       (event_v),
    .pc_id_i       (pc_id),
    .hart_id_i     (hart_id),
    .clear_i       (clear),
    .rd_ready_i    (rd_ready),
    .rd_valid_o    (rd_valid),
    .rd_event_o    (rd_event),
    .rd_pc_o       (rd_pc),
    .rd_ts_o       (rd_ts),
    .level_o       (level),
    .overflow_o    (overflow),
    .count_o       (count)
  );

  // ---------------- reference model ----------------
  logic [TW-1:0] m_ts;
  logic [RW-1:0] exp_q[$];
  logic [CW-1:0] exp_cnt [NE];
  logic          exp_ovf;
  int            n_checks = 0;
  int            n_errors = 0;

  // Cycle counter used as the expected timestamp of a record pushed next edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ts <= '0;
    else        m_ts <= m_ts + 1'b1;
  end

  task automatic check_eq(input string tag, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < NE; k++) exp_cnt[k] = '0;
    exp_ovf = 1'b0;
  endtask

  // ---------------- driver ----------------
  // Applies one cycle of inputs, updates the model, returns at the next negedge.
  task automatic drive(input logic dec, input logic [NE-1:0] ev, input logic [31:0] pc,
                       input logic rdy, input logic clr);
    logic       pop;
    logic       hit;
    logic [1:0] first;
    is_decoding = dec;
    event_v     = ev;
    pc_id       = pc;
    rd_ready    = rdy;
    clear       = clr;
    pop   = (exp_q.size() > 0) && rdy;
    hit   = dec && (ev != '0);
    first = 2'd0;
    for (int k = NE - 1; k >= 0; k--) if (ev[k]) first = 2'(k);
    if (clr) begin
      model_reset();
    end else begin
      for (int k = 0; k < NE; k++)
        if (dec && ev[k] && exp_cnt[k] != {CW{1'b1}}) exp_cnt[k] = exp_cnt[k] + 1'b1;
      if (pop) void'(exp_q.pop_front());
      if (hit) begin
        if (exp_q.size() < DEP) exp_q.push_back({first, pc, m_ts});
        else                    exp_ovf = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    is_decoding = 1'b0;
    event_v     = '0;
    pc_id       = '0;
    rd_ready    = 1'b0;
    clear       = 1'b0;
  endtask

  // Full comparison of DUT outputs against the model.
  task automatic check_state(input string tag);
    check_eq({tag, "_valid"}, rd_valid, exp_q.size() > 0);
    check_eq({tag, "_level"}, level, exp_q.size());
    check_eq({tag, "_ovf"}, overflow, exp_ovf);
    for (int k = 0; k < NE; k++)
      check_eq($sformatf("%s_cnt%0d", tag, k), count[k*CW +: CW], exp_cnt[k]);
    if (exp_q.size() > 0) check_eq({tag, "_head"}, {rd_event, rd_pc, rd_ts}, exp_q[0]);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int guard;
    hart_id = 32'd3;
    idle_inputs();
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check_state("rst");
    check_eq("rst_fields", {rd_event, rd_pc, rd_ts}, '0);

    // Single ch0 event at timestamp 5
    guard = 0;
    while (m_ts != 5 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    drive(1'b1, 4'b0001, 32'h80, 1'b0, 1'b0);
    idle_inputs();
    check_eq("a_valid", rd_valid, 1'b1);
    check_eq("a_event", rd_event, 0);
    check_eq("a_pc", rd_pc, 32'h80);
    check_eq("a_ts", rd_ts, 5);
    check_eq("a_cnt0", count[3:0], 1);
    check_state("a");

    drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    check_eq("a_pop_level", level, 0);
    check_state("a_pop");

    // Two simultaneous channels: one record (lowest), both counted
    drive(1'b1, 4'b0110, 32'h100, 1'b0, 1'b0);
    check_eq("b_event", rd_event, 1);
    check_eq("b_pc", rd_pc, 32'h100);
    check_eq("b_cnt1", count[7:4], 1);
    check_eq("b_cnt2", count[11:8], 1);
    check_state("b");

    // Unqualified event: nothing happens
    drive(1'b0, 4'b1000, 32'h180, 1'b0, 1'b0);
    check_eq("nodec_level", level, 1);
    check_eq("nodec_cnt3", count[15:12], 0);
    check_state("nodec");

    drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    check_state("b_pop");

    // Nine pushes with no consumer: ninth dropped
    for (int i = 0; i < 9; i++) drive(1'b1, 4'b0100, 32'h200 + 4 * i, 1'b0, 1'b0);
    idle_inputs();
    check_eq("full_level", level, 8);
    check_eq("full_ovf", overflow, 1'b1);
    check_eq("full_cnt2", count[11:8], 10);
    check_state("full");

    // Drain eight in push order
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("drain%0d_pc", i), rd_pc, 32'h200 + 4 * i);
      check_state($sformatf("drain%0d", i));
      drive(1'b0, 4'b0000, 32'h0, 1'b1, 1'b0);
    end
    idle_inputs();
    check_eq("drained_level", level, 0);
    check_state("drained");

    // Refill, then push with pop while full: accepted, level stays 8
    for (int i = 0; i < 8; i++) drive(1'b1, 4'b0001, 32'h400 + 4 * i, 1'b0, 1'b0);
    drive(1'b1, 4'b0001, 32'h500, 1'b1, 1'b0);
    idle_inputs();
    check_eq("pushpop_level", level, 8);
    check_eq("pushpop_head", rd_pc, 32'h404);
    check_state("pushpop");

    // Counter saturation on ch3
    for (int i = 0; i < 20; i++) drive(1'b1, 4'b1000, 32'h600, 1'b0, 1'b0);
    idle_inputs();
    check_eq("sat_cnt3", count[15:12], 15);
    check_state("sat");

    // Clear overrides a simultaneous event
    drive(1'b1, 4'b0011, 32'h700, 1'b0, 1'b1);
    idle_inputs();
    check_eq("clr_level", level, 0);
    check_eq("clr_ovf", overflow, 1'b0);
    check_eq("clr_counts", count, 0);
    check_state("clr");

    // Asynchronous reset in the middle of a drain with five records queued
    for (int i = 0; i < 5; i++) drive(1'b1, 4'b0010, 32'h800 + 4 * i, 1'b0, 1'b0);
    idle_inputs();
    check_eq("pre_rst_level", level, 5);
    rd_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("arst_valid", rd_valid, 1'b0);
    check_eq("arst_level", level, 0);
    check_eq("arst_fields", {rd_event, rd_pc, rd_ts}, '0);
    check_state("arst");
    @(negedge clk);
    rd_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check_state("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
